// File: rtl/wb_host_master.sv
// Wishbone classic initiator that turns a command/response stream into
// single read/write transfers on the user-project slave port. It has a bus
// timeout and error status, so a hung or erroring responder cannot stall the
// command source.
module wb_host_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TO_W           = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [31:0] cmd_adr_i,
   input  logic [31:0] cmd_dat_i,
   input  logic [3:0]  cmd_sel_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_dat_o,
   output logic [1:0]  rsp_status_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_ERR = 2'b01;
   localparam logic [1:0] ST_TO  = 2'b10;

   // A TIMEOUT_CYCLES of zero disables the timeout, so the terminal count is unused.
   localparam bit              TO_EN     = (TIMEOUT_CYCLES != 0);
   localparam int unsigned     TO_LAST_I = TO_EN ? (TIMEOUT_CYCLES - 1) : 0;
   localparam logic [TO_W-1:0] TO_LAST   = TO_LAST_I[TO_W-1:0];

   state_t          state;
   logic [TO_W-1:0] to_cnt;
   logic            cmd_take;
   logic            to_hit;
   logic            bus_done;

   // These feed only registers, so the wbm_* inputs never reach an output combinationally.
   assign cmd_take = (state == IDLE) && cmd_valid_i && cmd_ready_o;
   assign to_hit   = TO_EN && (to_cnt == TO_LAST);
   assign bus_done = wbm_ack_i || wbm_err_i || to_hit;

   // Control FSM: handshakes, bus strobes, response status and the timeout counter.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state        <= IDLE;
         cmd_ready_o  <= 1'b0;
         wbm_cyc_o    <= 1'b0;
         wbm_stb_o    <= 1'b0;
         rsp_valid_o  <= 1'b0;
         rsp_status_o <= ST_OK;
         to_cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_take) begin
                  state       <= BUS;
                  cmd_ready_o <= 1'b0;
                  wbm_cyc_o   <= 1'b1;
                  wbm_stb_o   <= 1'b1;
                  to_cnt      <= '0;
               end else begin
                  cmd_ready_o <= 1'b1;
               end
            end
            BUS: begin
               if (bus_done) begin
                  state       <= RESP;
                  wbm_cyc_o   <= 1'b0;
                  wbm_stb_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  to_cnt      <= '0;
                  if (wbm_ack_i) begin
                     rsp_status_o <= ST_OK;
                  end else if (wbm_err_i) begin
                     rsp_status_o <= ST_ERR;
                  end else begin
                     rsp_status_o <= ST_TO;
                  end
               end else if (TO_EN) begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state       <= IDLE;
                  rsp_valid_o <= 1'b0;
                  cmd_ready_o <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               cmd_ready_o <= 1'b0;
               wbm_cyc_o   <= 1'b0;
               wbm_stb_o   <= 1'b0;
               rsp_valid_o <= 1'b0;
               to_cnt      <= '0;
            end
         endcase
      end
   end

   // Datapath: latch the command onto the bus and capture read data on completion.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= 4'h0;
         wbm_adr_o <= 32'h0;
         wbm_dat_o <= 32'h0;
         rsp_dat_o <= 32'h0;
      end else begin
         if (cmd_take) begin
            wbm_we_o  <= cmd_we_i;
            wbm_sel_o <= cmd_sel_i;
            wbm_adr_o <= cmd_adr_i;
            wbm_dat_o <= cmd_dat_i;
         end
         if ((state == BUS) && bus_done) begin
            rsp_dat_o <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : 32'h0;
         end
      end
   end

endmodule

// File: tb/tb_wb_host_master.sv
// Self-checking bench for wb_host_master. A transaction-level model tracks
// commands accepted, bus transfers finished and responses consumed. It
// derives the expected outputs on every cycle. Directed tests add literal
// checks that pin the model.
module tb_wb_host_master;

   localparam int TO = 4;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_n_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_we_i = 1'b0;
   logic [31:0] cmd_adr_i = 32'h0;
   logic [31:0] cmd_dat_i = 32'h0;
   logic [3:0]  cmd_sel_i = 4'h0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_dat_o;
   logic [1:0]  rsp_status_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i = 32'h0;
   logic        wbm_ack_i = 1'b0;
   logic        wbm_err_i = 1'b0;

   int nCompared = 0;
   int nMismatched = 0;

   // Model state: counts of handshake events plus the latest command and result.
   int          mAccepted = 0;
   int          mDone = 0;
   int          mConsumed = 0;
   int          mBusCycles = 0;
   bit          mReady = 1'b0;
   logic        mWe = 1'b0;
   logic [3:0]  mSel = 4'h0;
   logic [31:0] mAdr = 32'h0;
   logic [31:0] mDat = 32'h0;
   logic [31:0] mRspDat = 32'h0;
   logic [1:0]  mRspStatus = 2'b00;

   // Snapshot of the last directed transaction.
   int          lastBusLen;
   logic        lastBusWe;
   logic [3:0]  lastBusSel;
   logic [31:0] lastBusAdr;
   logic [31:0] lastBusDat;
   logic        lastRspValid;
   logic [31:0] lastRspDat;
   logic [1:0]  lastRspStatus;

   wb_host_master #(
      .TIMEOUT_CYCLES(TO),
      .TO_W(8)
   ) dut (
      .wb_clk_i(wb_clk_i),
      .wb_rst_n_i(wb_rst_n_i),
      .cmd_valid_i(cmd_valid_i),
      .cmd_ready_o(cmd_ready_o),
      .cmd_we_i(cmd_we_i),
      .cmd_adr_i(cmd_adr_i),
      .cmd_dat_i(cmd_dat_i),
      .cmd_sel_i(cmd_sel_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_ready_i(rsp_ready_i),
      .rsp_dat_o(rsp_dat_o),
      .rsp_status_o(rsp_status_o),
      .wbm_cyc_o(wbm_cyc_o),
      .wbm_stb_o(wbm_stb_o),
      .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o),
      .wbm_adr_o(wbm_adr_o),
      .wbm_dat_o(wbm_dat_o),
      .wbm_dat_i(wbm_dat_i),
      .wbm_ack_i(wbm_ack_i),
      .wbm_err_i(wbm_err_i)
   );

   // Free-running bus clock, period 10.
   initial begin
      forever #5 wb_clk_i = ~wb_clk_i;
   end

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] required);
      nCompared++;
      if (actual !== required) begin
         nMismatched++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
      end
   endtask

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   // Model update: applies the transfer rules to the inputs seen at each rising edge.
   initial begin
      forever begin
         @(posedge wb_clk_i or negedge wb_rst_n_i);
         if (!wb_rst_n_i) begin
            mAccepted = 0;
            mDone = 0;
            mConsumed = 0;
            mBusCycles = 0;
            mReady = 1'b0;
            mWe = 1'b0;
            mSel = 4'h0;
            mAdr = 32'h0;
            mDat = 32'h0;
            mRspDat = 32'h0;
            mRspStatus = 2'b00;
         end else begin
            if (mAccepted > mDone) begin
               if (wbm_ack_i) begin
                  mRspStatus = 2'b00;
                  mRspDat = mWe ? 32'h0 : wbm_dat_i;
                  mDone++;
                  mBusCycles = 0;
               end else if (wbm_err_i) begin
                  mRspStatus = 2'b01;
                  mRspDat = 32'h0;
                  mDone++;
                  mBusCycles = 0;
               end else if (TO != 0 && mBusCycles + 1 == TO) begin
                  mRspStatus = 2'b10;
                  mRspDat = 32'h0;
                  mDone++;
                  mBusCycles = 0;
               end else begin
                  mBusCycles++;
               end
            end else if (mDone > mConsumed) begin
               if (rsp_ready_i) mConsumed++;
            end else if (mReady && cmd_valid_i) begin
               mAccepted++;
               mWe = cmd_we_i;
               mSel = cmd_sel_i;
               mAdr = cmd_adr_i;
               mDat = cmd_dat_i;
            end
            mReady = (mAccepted == mConsumed);
         end
      end
   end

   // Compare process: checks DUT outputs against the model on every falling edge.
   initial begin
      forever begin
         @(negedge wb_clk_i);
         checkOutput("model cmd_ready", cmd_ready_o, mReady);
         checkOutput("model cyc_stb", {wbm_cyc_o, wbm_stb_o}, {2{mAccepted > mDone}});
         checkOutput("model rsp_valid", rsp_valid_o, mDone > mConsumed);
         if (mAccepted > mDone) begin
            checkOutput("model bus fields", {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o},
                        {mWe, mSel, mAdr, mDat});
         end
         if (mDone > mConsumed) begin
            checkOutput("model rsp fields", {rsp_status_o, rsp_dat_o}, {mRspStatus, mRspDat});
         end
      end
   end

   // One command with a scripted responder: ack/err on a given bus cycle (-1 = never).
   task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input int ackAt, input int errAt,
                                input logic [31:0] rdata, input int holdCycles);
      int guard;
      guard = 0;
      while (cmd_ready_o !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      checkOutput("cmd_ready wait bound", guard < 20, 1'b1);
      cmd_valid_i = 1'b1;
      cmd_we_i = we;
      cmd_adr_i = adr;
      cmd_dat_i = dat;
      cmd_sel_i = sel;
      rsp_ready_i = (holdCycles == 0);
      tick();
      cmd_valid_i = 1'b0;
      lastBusWe = wbm_we_o;
      lastBusSel = wbm_sel_o;
      lastBusAdr = wbm_adr_o;
      lastBusDat = wbm_dat_o;
      lastBusLen = 0;
      while (wbm_cyc_o === 1'b1 && lastBusLen < 20) begin
         wbm_ack_i = (lastBusLen == ackAt);
         wbm_err_i = (lastBusLen == errAt);
         wbm_dat_i = rdata;
         tick();
         lastBusLen++;
      end
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      checkOutput("bus wait bound", lastBusLen < 20, 1'b1);
      lastRspValid = rsp_valid_o;
      lastRspDat = rsp_dat_o;
      lastRspStatus = rsp_status_o;
      for (int i = 0; i < holdCycles; i++) begin
         tick();
         checkOutput("hold rsp_valid", rsp_valid_o, 1'b1);
         checkOutput("hold cmd_ready", cmd_ready_o, 1'b0);
      end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
   endtask

   // Directed test sequence.
   initial begin
      int accCyc[3];
      int nAcc;
      int nRsp;
      int nAckDrv;

      #2 wb_rst_n_i = 1'b0;
      repeat (3) tick();
      checkOutput("reset cmd_ready", cmd_ready_o, 1'b0);
      checkOutput("reset bus ctrl", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 7'h0);
      checkOutput("reset bus adr_dat", {wbm_adr_o, wbm_dat_o}, 64'h0);
      checkOutput("reset rsp", {rsp_valid_o, rsp_status_o, rsp_dat_o}, 35'h0);
      wb_rst_n_i = 1'b1;
      tick();
      checkOutput("idle cmd_ready", cmd_ready_o, 1'b1);

      $display("[TB] write with immediate ack");
      applyStimulus(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0, -1, 32'hDEAD_BEEF, 0);
      checkOutput("wr bus len", lastBusLen, 1);
      checkOutput("wr bus fields", {lastBusWe, lastBusSel, lastBusAdr, lastBusDat},
                  {1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_1234});
      checkOutput("wr rsp", {lastRspValid, lastRspStatus, lastRspDat}, {1'b1, 2'b00, 32'h0});

      $display("[TB] read with 3-cycle ack delay and stalled response");
      applyStimulus(1'b0, 32'h3000_0008, 32'h0, 4'hF, 3, -1, 32'hCAFE_F00D, 5);
      checkOutput("rd bus len", lastBusLen, 4);
      checkOutput("rd rsp", {lastRspValid, lastRspStatus, lastRspDat}, {1'b1, 2'b00, 32'hCAFE_F00D});

      $display("[TB] timeout then late ack");
      applyStimulus(1'b0, 32'h3000_000C, 32'h0, 4'h3, -1, -1, 32'h1111_2222, 0);
      checkOutput("to bus len", lastBusLen, 4);
      checkOutput("to rsp", {lastRspValid, lastRspStatus, lastRspDat}, {1'b1, 2'b10, 32'h0});
      tick();
      wbm_ack_i = 1'b1;
      wbm_dat_i = 32'h9999_9999;
      tick();
      wbm_ack_i = 1'b0;
      tick();
      checkOutput("late ack ignored", {cmd_ready_o, rsp_valid_o, wbm_cyc_o}, 3'b100);

      $display("[TB] ack+err together, then err alone");
      applyStimulus(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1, 1, 32'h5A5A_0001, 0);
      checkOutput("ackerr bus len", lastBusLen, 2);
      checkOutput("ackerr rsp", {lastRspStatus, lastRspDat}, {2'b00, 32'h5A5A_0001});
      applyStimulus(1'b0, 32'h3000_0014, 32'h0, 4'hF, -1, 0, 32'h7777_8888, 0);
      checkOutput("err bus len", lastBusLen, 1);
      checkOutput("err rsp", {lastRspStatus, lastRspDat}, {2'b01, 32'h0});

      $display("[TB] reset during bus cycle");
      cmd_valid_i = 1'b1;
      cmd_we_i = 1'b1;
      cmd_adr_i = 32'h3000_0020;
      cmd_dat_i = 32'h1234_5678;
      cmd_sel_i = 4'hF;
      tick();
      cmd_valid_i = 1'b0;
      checkOutput("pre-reset cyc", wbm_cyc_o, 1'b1);
      #2 wb_rst_n_i = 1'b0;
      #1;
      checkOutput("async reset bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, 71'h0);
      tick();
      wb_rst_n_i = 1'b1;
      tick();
      checkOutput("post-reset state", {rsp_valid_o, cmd_ready_o}, 2'b01);
      applyStimulus(1'b0, 32'h3000_0024, 32'h0, 4'hF, 0, -1, 32'h0BAD_C0DE, 0);
      checkOutput("post-reset rd", {lastRspStatus, lastRspDat}, {2'b00, 32'h0BAD_C0DE});

      $display("[TB] back-to-back reads");
      accCyc = '{0, 0, 0};
      nAcc = 0;
      nRsp = 0;
      nAckDrv = 0;
      cmd_we_i = 1'b0;
      cmd_sel_i = 4'hF;
      cmd_adr_i = 32'h3000_0040;
      cmd_valid_i = 1'b1;
      rsp_ready_i = 1'b1;
      for (int c = 0; c < 14; c++) begin
         if (wbm_cyc_o === 1'b1) begin
            nAckDrv++;
            wbm_ack_i = 1'b1;
            wbm_dat_i = 32'(nAckDrv);
         end else begin
            wbm_ack_i = 1'b0;
         end
         if (rsp_valid_o === 1'b1) begin
            nRsp++;
            checkOutput("b2b rsp", {rsp_status_o, rsp_dat_o}, {2'b00, 32'(nRsp)});
         end
         if (cmd_valid_i && cmd_ready_o === 1'b1) begin
            if (nAcc < 3) accCyc[nAcc] = c;
            nAcc++;
         end
         tick();
         if (nAcc >= 3) cmd_valid_i = 1'b0;
         else cmd_adr_i = 32'h3000_0040 + 32'(4 * nAcc);
      end
      wbm_ack_i = 1'b0;
      rsp_ready_i = 1'b0;
      checkOutput("b2b rsp count", nRsp, 3);
      checkOutput("b2b gap 1", accCyc[1] - accCyc[0], 3);
      checkOutput("b2b gap 2", accCyc[2] - accCyc[1], 3);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
- Wishbone classic initiator that drives single read/write transfers into the user-project slave port (wbs_* responder) from a simple command/response stream.
- Used by test/bring-up logic (e.g. a UART command decoder) to reach user-project registers without the management core.
- Adds a bus timeout and error status so a hung or erroring responder never stalls the command source.

Parameters:
- TIMEOUT_CYCLES, 255: maximum bus cycles to wait for ack/err; 0 disables the timeout.
- TO_W, 8: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- wb_clk_i  input  1  bus clock; all logic rises on this edge.
- wb_rst_n_i  input  1  asynchronous active-low reset.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  command accepted when high together with cmd_valid_i.
- cmd_we_i  input  1  1 = write, 0 = read.
- cmd_adr_i  input  32  byte address.
- cmd_dat_i  input  32  write data.
- cmd_sel_i  input  4  byte lanes.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  response consumed when high together with rsp_valid_o.
- rsp_dat_o  output  32  read data; 0 for writes, errors and timeouts.
- rsp_status_o  output  2  00 ok, 01 bus error, 10 timeout.
- wbm_cyc_o  output  1  Wishbone cycle.
- wbm_stb_o  output  1  Wishbone strobe.
- wbm_we_o  output  1  Wishbone write enable.
- wbm_sel_o  output  4  Wishbone byte select.
- wbm_adr_o  output  32  Wishbone address.
- wbm_dat_o  output  32  Wishbone write data.
- wbm_dat_i  input  32  Wishbone read data.
- wbm_ack_i  input  1  Wishbone acknowledge.
- wbm_err_i  input  1  Wishbone error; tie 0 if the responder has none.

Behaviour:
- Reset values (async, while wb_rst_n_i = 0): state IDLE; cmd_ready_o = 0 during reset, then 1 in IDLE.
  - All wbm_* outputs, rsp_valid_o, rsp_dat_o, rsp_status_o and the timeout counter reset to 0.
- FSM has three states: IDLE, BUS, RESP.
- IDLE: cmd_ready_o = 1.
  - On cmd_valid_i & cmd_ready_o at edge t0: register we/adr/dat/sel onto wbm_* and go to BUS.
  - wbm_cyc_o = wbm_stb_o = 1 from cycle t0+1.
- BUS: cmd_ready_o = 0; wbm_cyc_o/stb_o held high; wbm_adr/dat/sel/we held stable.
  - Counter increments once per BUS cycle, starting at 0.
- BUS exit priority, evaluated at each edge:
  1. wbm_ack_i = 1: status 00; rsp_dat_o = wbm_dat_i for a read, 0 for a write.
  2. Else wbm_err_i = 1: status 01, rsp_dat_o = 0.
  3. Else TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: status 10, rsp_dat_o = 0.
  - On any exit, cyc/stb drop to 0 in the next cycle, rsp_valid_o = 1, and the FSM goes to RESP.
- ack and err asserted together: ack wins (status 00).
- ack arriving in the same cycle as the timeout terminal count: ack wins.
- Minimum latency: command accepted at t0, bus cycle t0+1, ack sampled at the end of t0+1, rsp_valid_o high in t0+2.
  - Command-to-command throughput is therefore at least 3 cycles when rsp_ready_i is held high.
- RESP: rsp_valid_o, rsp_dat_o and rsp_status_o are held stable until rsp_ready_i = 1.
  - On that edge rsp_valid_o clears and the FSM returns to IDLE.
  - cmd_ready_o stays 0 throughout RESP, so at most one transaction is outstanding.
- wbm_ack_i and wbm_err_i are ignored outside BUS; stray pulses change no state.
- After the timeout, a late ack is ignored.
- Timeout counter: clears on entry to BUS; never wraps, because the exit fires at the terminal count.
- Reset asserted mid-transfer: cyc/stb drop immediately (asynchronously) and any pending response is discarded.
- Implementation scope: single always block for the FSM plus a datapath register block; no combinational path from wbm_* inputs to any output.

Test Plan:
- Write, responder acks on the first bus cycle: cmd we=1, adr=0x3000_0004, dat=0xA5A5_1234, sel=0xF.
  - Required: cyc/stb high exactly 1 cycle with those values; rsp_valid_o in t0+2; status 00, rsp_dat_o=0.
- Read with a 3-cycle ack delay, wbm_dat_i=0xCAFE_F00D.
  - Required: cyc high 4 cycles; rsp_dat_o=0xCAFE_F00D, status 00.
  - Hold rsp_ready_i=0 for 5 cycles: response stays stable and cmd_ready_o stays 0.
- No ack, TIMEOUT_CYCLES=4.
  - Required: cyc high exactly 4 cycles; rsp status 10, dat 0.
  - A late ack 2 cycles afterwards causes no state change.
- ack and err asserted together on the 2nd bus cycle -> status 00.
  - err alone on the next transaction -> status 01.
- wb_rst_n_i pulsed low during BUS -> all wbm_* outputs 0 at once; after release, rsp_valid_o=0, cmd_ready_o=1.
  - A new read then completes normally.
- Back-to-back commands with cmd_valid_i and rsp_ready_i held high and 0-wait acks -> a new transaction every 3 cycles.
  - Each response carries the matching read data, e.g. 0x1, 0x2, 0x3.
